load_store_unit: RTL

Execute-stage neighbour directly downstream of the ALU. It takes the ALU result as the effective address, plus rs2 store data and funct3, and runs one request/acknowledge transaction to data memory. It formats byte lanes for stores and aligns and extends load data. It returns the writeback result to the pipeline and stalls upstream via req_ready while a transaction is outstanding.

---
 rtl/load_store_unit_pkg.sv | 40 ++++
 rtl/load_store_unit_if.sv | 33 +++
 rtl/lsu_data_align.sv | 55 +++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared load/store encodings, FSM state type and the access-legality check.
package load_store_unit_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    // RV32I funct3 width/sign encodings for loads and stores
    localparam logic [2:0] LSU_F3_B  = 3'd0;
    localparam logic [2:0] LSU_F3_H  = 3'd1;
    localparam logic [2:0] LSU_F3_W  = 3'd2;
    localparam logic [2:0] LSU_F3_BU = 3'd4;
    localparam logic [2:0] LSU_F3_HU = 3'd5;

    typedef enum logic [0:0] {
        LsuIdle = 1'b0,
        LsuWait = 1'b1
    } lsu_state_e;

    // True when the access is misaligned or funct3 is not a legal width for the direction.
    function automatic logic lsu_is_fault(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (we) begin
            if (f3 > LSU_F3_W) begin
                bad = 1'b1;
            end
        end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
            bad = 1'b1;
        end
        if ((f3 == LSU_F3_H || f3 == LSU_F3_HU) && off[0]) begin
            bad = 1'b1;
        end
        if (f3 == LSU_F3_W && off != 2'b00) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            dmem_req;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_we;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_addr,
        output dmem_we,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_addr,
        input  dmem_we,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store byte-enables and data replication, load extract/extend.
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_off_i,
    input  logic [XLEN-1:0] st_data_i,
    output logic [3:0]      st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_off_i,
    input  logic [XLEN-1:0] ld_raw_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic [XLEN-1:0] ld_shift;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    // Store formatting: replicate data across lanes so memory only needs the byte enables
    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_funct3_i)
            LSU_F3_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            LSU_F3_H: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
        endcase
    end

    // Load extraction: select the lane, then sign- or zero-extend
    always_comb begin
        ld_shift  = ld_raw_i >> {ld_off_i, 3'b000};
        ld_byte   = ld_shift[7:0];
        ld_half   = ld_off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        ld_data_o = ld_raw_i;
        case (ld_funct3_i)
            LSU_F3_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            LSU_F3_BU: ld_data_o = {24'd0, ld_byte};
            LSU_F3_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            LSU_F3_HU: ld_data_o = {16'd0, ld_half};
            default:   ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory transaction, lane formatting and fault detection.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [2:0]                req_funct3_i,
    input  logic [XLEN-1:0]           req_addr_i,
    input  logic [XLEN-1:0]           req_wdata_i,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd_i,
    load_store_unit_if.master         dmem,
    output logic                      resp_valid_o,
    output logic [XLEN-1:0]           resp_rdata_o,
    output logic [REG_ADDR_WIDTH-1:0] resp_rd_o,
    output logic                      fault_o,
    output logic [XLEN-1:0]           fault_addr_o
);

    lsu_state_e                state_q, state_d;
    logic                      dmem_req_q, dmem_req_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic                      we_q, we_d;
    logic [3:0]                be_q, be_d;
    logic [XLEN-1:0]           wdata_q, wdata_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                off_q, off_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]           resp_rdata_q, resp_rdata_d;
    logic [REG_ADDR_WIDTH-1:0] resp_rd_q, resp_rd_d;
    logic                      fault_q, fault_d;
    logic [XLEN-1:0]           fault_addr_q, fault_addr_d;

    logic                      accept;
    logic [3:0]                st_be;
    logic [XLEN-1:0]           st_wdata;
    logic [XLEN-1:0]           ld_data;

    // Store lanes come from the live request; load lanes from the latched request.
    lsu_data_align u_align (
        .st_funct3_i (req_funct3_i),
        .st_off_i    (req_addr_i[1:0]),
        .st_data_i   (req_wdata_i),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .ld_raw_i    (dmem.dmem_rdata),
        .ld_data_o   (ld_data)
    );

    // Ready only in IDLE and never while reset is asserted
    always_comb begin
        req_ready_o = (state_q == LsuIdle) && !rst_i;
        accept      = req_valid_i && req_ready_o;
    end

    // Next-state: accept/fault in IDLE, complete on ack in WAIT
    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;

        unique case (state_q)
            LsuIdle: begin
                if (accept) begin
                    if (lsu_is_fault(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
                        fault_d      = 1'b1;
                        fault_addr_d = req_addr_i;
                    end else begin
                        addr_d     = {req_addr_i[XLEN-1:2], 2'b00};
                        we_d       = req_we_i;
                        be_d       = req_we_i ? st_be : 4'b1111;
                        wdata_d    = req_we_i ? st_wdata : '0;
                        funct3_d   = req_funct3_i;
                        off_d      = req_addr_i[1:0];
                        rd_d       = req_rd_i;
                        dmem_req_d = 1'b1;
                        state_d    = LsuWait;
                    end
                end
            end
            LsuWait: begin
                if (dmem.dmem_ack) begin
                    dmem_req_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? '0 : ld_data;
                    resp_rd_d    = we_q ? '0 : rd_q;
                    state_d      = LsuIdle;
                end
            end
            default: state_d = LsuIdle;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LsuIdle;
            dmem_req_q   <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            wdata_q      <= '0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Registered outputs
    always_comb begin
        dmem.dmem_req   = dmem_req_q;
        dmem.dmem_addr  = addr_q;
        dmem.dmem_we    = we_q;
        dmem.dmem_be    = be_q;
        dmem.dmem_wdata = wdata_q;
        resp_valid_o    = resp_valid_q;
        resp_rdata_o    = resp_rdata_q;
        resp_rd_o       = resp_rd_q;
        fault_o         = fault_q;
        fault_addr_o    = fault_addr_q;
    end

endmodule
